// File: rtl/c2_ms_serial_converter.sv
// Serial two's-complement to sign-magnitude converter.
// One operand bit per clock, LSB first, with valid/ready on both sides.
module c2_ms_serial_converter #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [N-1:0] x,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] abs,
    output logic         sgn,
    output logic         ow,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  xr;
    logic [N-1:0]  res;
    logic          f;
    logic          bit_i;
    logic          res_bit;

    // Negation by "copy up to and including the first 1, then invert"
    always_comb begin
        bit_i   = xr[cnt];
        res_bit = sgn ? (bit_i ^ f) : bit_i;
    end

    assign abs = res;

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state     <= IDLE;
            cnt       <= '0;
            xr        <= '0;
            res       <= '0;
            f         <= 1'b0;
            sgn       <= 1'b0;
            ow        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        xr       <= x;
                        sgn      <= x[N-1];
                        ow       <= (x == MOST_NEG);
                        cnt      <= '0;
                        f        <= 1'b0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    res <= {res_bit, res[N-1:1]};
                    f   <= f | bit_i;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
